// File: rtl/aes_encryption_pkg.sv
// Shared AES definitions: stage encodings, round indices and the
// GF(2^8)/state helpers used by the encryption datapath.
package aes_encryption_pkg;

    // Datapath stage encodings (KEY_WAIT only used by the single-cycle round build)
    localparam logic [2:0] ST_IDLE          = 3'd0;
    localparam logic [2:0] ST_ADD_ROUND_KEY = 3'd1;
    localparam logic [2:0] ST_SUB_BYTES     = 3'd2;
    localparam logic [2:0] ST_SHIFT_ROWS    = 3'd3;
    localparam logic [2:0] ST_MIX_COLUMNS   = 3'd4;
    localparam logic [2:0] ST_KEY_WAIT      = 3'd5;

    // Round indices presented by the key-schedule controller
    localparam logic [3:0] ROUND_INIT = 4'd0;
    localparam logic [3:0] ROUND_1    = 4'd1;
    localparam logic [3:0] ROUND_9    = 4'd9;
    localparam logic [3:0] ROUND_10   = 4'd10;

    // Multiply by x in GF(2^8), reduction polynomial 0x11b
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte n of the state (n = row + 4*column), FIPS byte 0 at [127:120]
    function automatic logic [7:0] get_byte(input logic [127:0] s, input int n);
        return s[127-8*n -: 8];
    endfunction

    // Row r rotated left by r byte positions
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = get_byte(s, 4*((c+r)%4) + r);
            end
        end
        return o;
    endfunction

    // Each column multiplied by circulant (02,03,01,01)
    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = get_byte(s, 4*c);
            a1 = get_byte(s, 4*c+1);
            a2 = get_byte(s, 4*c+2);
            a3 = get_byte(s, 4*c+3);
            o[127-8*(4*c)   -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[127-8*(4*c+1) -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[127-8*(4*c+3) -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational 128-bit forward S-box: 16 independent byte lookups.
// Companion of the inverse S-box used by the decryption core.
module aes_sbox (
    input  logic [127:0] i_data,
    output logic [127:0] o_data
);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    for (genvar i = 0; i < 16; i++) begin : g_byte
        assign o_data[8*i +: 8] = SBOX[i_data[8*i +: 8]];
    end

endmodule

// File: rtl/aes_encryption.sv
// Iterative AES-128 encryption datapath. Round keys arrive from an external
// key-schedule controller on round_in/key_in, paced by next_round_out.
// Optional build macro AES_ENC_SINGLE_CYCLE_ROUND_EN: one full round per
// compute cycle followed by a KEY_WAIT cycle (21-cycle latency); default is
// one transform stage per cycle (40-cycle latency).
//
// stage            | meaning
// IDLE             | no block in flight, data_out holds the last result
// ADD_ROUND_KEY    | XOR key_in into state; round 10 finishes the block
// SUB_BYTES        | forward S-box on all 16 bytes
// SHIFT_ROWS       | rotate row r left by r bytes
// MIX_COLUMNS      | column mix, then back to ADD_ROUND_KEY
// KEY_WAIT         | single-cycle build: controller advancing round/key
module aes_encryption
    import aes_encryption_pkg::*;
(
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         init_in,
    input  logic [127:0] data_in,
    input  logic [127:0] key_in,
    input  logic [3:0]   round_in,
    output logic         next_round_out,
    output logic [127:0] data_out,
    output logic         valid_out,
    output logic         busy_out
);

    logic [127:0] r_state;
    logic [2:0]   r_stage;
    logic         r_valid;
    logic         r_busy;
    logic         r_next_round;

    logic [127:0] w_sub;
    logic         w_stall;

    aes_sbox u_sbox (
        .i_data (r_state),
        .o_data (w_sub)
    );

    // Out-of-range round index from the controller freezes a block in flight
    assign w_stall = r_busy && (round_in > ROUND_10);

`ifdef AES_ENC_SINGLE_CYCLE_ROUND_EN
    logic [127:0] w_shift_sub;
    logic [127:0] w_mix_sub;
    logic [127:0] w_round;

    assign w_shift_sub = shift_rows(w_sub);
    assign w_mix_sub   = mix_columns(w_shift_sub);

    // Whole-round result: round 0 is key add only, round 10 skips the column mix
    always_comb begin
        w_round = r_state ^ key_in;
        if (round_in == ROUND_10) begin
            w_round = w_shift_sub ^ key_in;
        end else if (round_in != ROUND_INIT) begin
            w_round = w_mix_sub ^ key_in;
        end
    end

    // Round sequencer: compute cycle then KEY_WAIT while the controller advances
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state      <= '0;
            r_stage      <= ST_IDLE;
            r_valid      <= 1'b0;
            r_busy       <= 1'b0;
            r_next_round <= 1'b0;
        end else if (init_in) begin
            r_state      <= data_in;
            r_stage      <= ST_ADD_ROUND_KEY;
            r_valid      <= 1'b0;
            r_busy       <= 1'b1;
            r_next_round <= 1'b0;
        end else begin
            r_valid      <= 1'b0;
            r_next_round <= 1'b0;
            if (!w_stall) begin
                case (r_stage)
                    ST_IDLE: begin
                        r_stage <= ST_IDLE;
                    end
                    ST_ADD_ROUND_KEY: begin
                        r_state <= w_round;
                        if (round_in == ROUND_10) begin
                            r_stage <= ST_IDLE;
                            r_valid <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_stage      <= ST_KEY_WAIT;
                            r_next_round <= 1'b1;
                        end
                    end
                    ST_KEY_WAIT: begin
                        r_stage <= ST_ADD_ROUND_KEY;
                    end
                    default: begin
                        r_stage <= ST_IDLE;
                    end
                endcase
            end
        end
    end
`else
    logic [127:0] w_shift;
    logic [127:0] w_mix;

    assign w_shift = shift_rows(r_state);
    assign w_mix   = mix_columns(r_state);

    // Stage sequencer: one transform of the state register per cycle
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state      <= '0;
            r_stage      <= ST_IDLE;
            r_valid      <= 1'b0;
            r_busy       <= 1'b0;
            r_next_round <= 1'b0;
        end else if (init_in) begin
            r_state      <= data_in;
            r_stage      <= ST_ADD_ROUND_KEY;
            r_valid      <= 1'b0;
            r_busy       <= 1'b1;
            r_next_round <= 1'b0;
        end else begin
            r_valid      <= 1'b0;
            r_next_round <= 1'b0;
            if (!w_stall) begin
                case (r_stage)
                    ST_IDLE: begin
                        r_stage <= ST_IDLE;
                    end
                    ST_ADD_ROUND_KEY: begin
                        r_state <= r_state ^ key_in;
                        if (round_in == ROUND_10) begin
                            r_stage <= ST_IDLE;
                            r_valid <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_stage      <= ST_SUB_BYTES;
                            r_next_round <= 1'b1;
                        end
                    end
                    ST_SUB_BYTES: begin
                        r_state <= w_sub;
                        r_stage <= ST_SHIFT_ROWS;
                    end
                    ST_SHIFT_ROWS: begin
                        r_state <= w_shift;
                        // round_in has already advanced to the round being built here
                        if (round_in >= ROUND_1 && round_in <= ROUND_9) begin
                            r_stage <= ST_MIX_COLUMNS;
                        end else begin
                            r_stage <= ST_ADD_ROUND_KEY;
                        end
                    end
                    ST_MIX_COLUMNS: begin
                        r_state <= w_mix;
                        r_stage <= ST_ADD_ROUND_KEY;
                    end
                    default: begin
                        r_stage <= ST_IDLE;
                    end
                endcase
            end
        end
    end
`endif

    assign data_out       = r_state;
    assign valid_out      = r_valid;
    assign busy_out       = r_busy;
    assign next_round_out = r_next_round;

endmodule

// File: tb/tb_aes_encryption.sv
// Scoreboard bench for aes_encryption with a behavioural key-schedule
// controller serving the FIPS-197 round keys for two known keys.
module tb_aes_encryption;

`ifdef AES_ENC_SINGLE_CYCLE_ROUND_EN
    localparam int LAT = 21;
`else
    localparam int LAT = 40;
`endif

    localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;

    localparam logic [127:0] RKC [0:10] = '{
        128'h000102030405060708090a0b0c0d0e0f,
        128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
        128'hb692cf0b643dbdf1be9bc5006830b3fe,
        128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
        128'h47f7f7bc95353e03f96c32bcfd058dfd,
        128'h3caaa3e8a99f9deb50f3af57adf622aa,
        128'h5e390f7df7a69296a7553dc10aa31f6b,
        128'h14f9701ae35fe28c440adf4d4ea9c026,
        128'h47438735a41c65b9e016baf4aebf7ad2,
        128'h549932d1f08557681093ed9cbe2c974e,
        128'h13111d7fe3944a17f307a78b4d2b30c5
    };
    localparam logic [127:0] RKB [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    logic         clk_in = 1'b0;
    logic         rst_in;
    logic         init_in;
    logic [127:0] data_in;
    logic [127:0] key_in;
    logic [3:0]   round_in;
    logic         next_round_out;
    logic [127:0] data_out;
    logic         valid_out;
    logic         busy_out;

    always #5 clk_in = ~clk_in;

    aes_encryption dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .init_in        (init_in),
        .data_in        (data_in),
        .key_in         (key_in),
        .round_in       (round_in),
        .next_round_out (next_round_out),
        .data_out       (data_out),
        .valid_out      (valid_out),
        .busy_out       (busy_out)
    );

    typedef struct {
        logic [127:0] data;
        int           lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_pass   = 0;
    int   n_total  = 0;
    int   key_sel  = 0;
    int   stall_at = -1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Key-schedule controller: advances on the edge where it samples next_round_out
    initial begin
        int   ctl_r;
        int   ctl_cnt;
        logic nr, it, rs;
        ctl_r    = 0;
        ctl_cnt  = 0;
        round_in = 4'd0;
        key_in   = RKC[0];
        forever begin
            @(posedge clk_in);
            nr = next_round_out;
            it = init_in;
            rs = rst_in;
            #1;
            if (rs === 1'b1 || it === 1'b1) begin
                ctl_r   = 0;
                ctl_cnt = 0;
            end else begin
                ctl_cnt++;
                if (nr === 1'b1 && ctl_r < 10) ctl_r++;
            end
            if (stall_at >= 0 && ctl_cnt >= stall_at && ctl_cnt < stall_at + 5) round_in = 4'd12;
            else round_in = 4'(ctl_r);
            key_in = (key_sel == 1) ? RKB[ctl_r] : RKC[ctl_r];
        end
    end

    // Monitor: pops the scoreboard on every valid_out and checks the handshake
    initial begin
        int   cyc, init_cyc, nr_cnt, nr_wide, busy_gap;
        bit   active, prev_nr, chk_low;
        logic si, sr;
        exp_t e;
        cyc = 0; init_cyc = 0; nr_cnt = 0; nr_wide = 0; busy_gap = 0;
        active = 0; prev_nr = 0; chk_low = 0;
        forever begin
            @(posedge clk_in);
            si = init_in;
            sr = rst_in;
            #1;
            cyc++;
            if (sr === 1'b1) begin
                active  = 0;
                chk_low = 0;
            end else if (si === 1'b1) begin
                active   = 1;
                init_cyc = cyc;
                nr_cnt   = 0;
                nr_wide  = 0;
                busy_gap = 0;
            end
            if (chk_low) begin
                check("valid_single_cycle", 128'(valid_out), 128'd0);
                chk_low = 0;
            end
            if (next_round_out === 1'b1) begin
                nr_cnt++;
                if (prev_nr) nr_wide++;
            end
            prev_nr = (next_round_out === 1'b1);
            if (active && valid_out !== 1'b1 && busy_out !== 1'b1) busy_gap++;
            if (valid_out === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_valid", 128'(valid_out), 128'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("ciphertext", data_out, e.data);
                    check("latency", 128'(cyc - init_cyc), 128'(e.lat));
                    check("next_round_pulses", 128'(nr_cnt), 128'd10);
                    check("next_round_wide", 128'(nr_wide), 128'd0);
                    check("busy_gap", 128'(busy_gap), 128'd0);
                end
                active  = 0;
                chk_low = 1;
            end
        end
    end

    task automatic start_block(input logic [127:0] pt, input int sel, input bit push,
                               input int lat, input logic [127:0] ct);
        exp_t e;
        @(negedge clk_in);
        data_in = pt;
        key_sel = sel;
        init_in = 1'b1;
        if (push) begin
            e.data = ct;
            e.lat  = lat;
            sb_q.push_back(e);
        end
        @(negedge clk_in);
        init_in = 1'b0;
    endtask

    // Stimulus
    initial begin
        rst_in  = 1'b1;
        init_in = 1'b0;
        data_in = '0;
        repeat (3) @(negedge clk_in);
        check("reset_data_out", data_out, 128'd0);
        check("reset_valid", 128'(valid_out), 128'd0);
        check("reset_busy", 128'(busy_out), 128'd0);
        check("reset_next_round", 128'(next_round_out), 128'd0);
        rst_in = 1'b0;

        // FIPS-197 C.1
        start_block(PT_C1, 0, 1, LAT, CT_C1);
        repeat (LAT + 5) @(negedge clk_in);
        check("data_out_hold", data_out, CT_C1);

        // FIPS-197 Appendix B with round-1 intermediates
        start_block(PT_B, 1, 1, LAT, CT_B);
        @(posedge clk_in); #1;
        check("after_round0_key", data_out, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
`ifdef AES_ENC_SINGLE_CYCLE_ROUND_EN
        @(posedge clk_in); #1;
        check("key_wait_hold", data_out, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
        @(posedge clk_in); #1;
        check("after_round1", data_out, 128'ha49c7ff2689f352b6b5bea43026a5049);
`else
        @(posedge clk_in); #1;
        check("r1_sub_bytes", data_out, 128'hd42711aee0bf98f1b8b45de51e415230);
        @(posedge clk_in); #1;
        check("r1_shift_rows", data_out, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
        @(posedge clk_in); #1;
        check("r1_mix_columns", data_out, 128'h046681e5e0cb199a48f8d37a2806264c);
        @(posedge clk_in); #1;
        check("after_round1", data_out, 128'ha49c7ff2689f352b6b5bea43026a5049);
`endif
        repeat (LAT + 5) @(negedge clk_in);

        // Restart at cycle 15: only the second block completes
        start_block(PT_C1, 0, 0, 0, 128'd0);
        repeat (14) @(negedge clk_in);
        start_block(PT_B, 1, 1, LAT, CT_B);
        repeat (LAT + 5) @(negedge clk_in);

        // Reset at cycle 20, then a clean block
        start_block(PT_C1, 0, 0, 0, 128'd0);
        repeat (19) @(negedge clk_in);
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        check("midreset_data_out", data_out, 128'd0);
        check("midreset_busy", 128'(busy_out), 128'd0);
        check("midreset_valid", 128'(valid_out), 128'd0);
        check("midreset_next_round", 128'(next_round_out), 128'd0);
        @(negedge clk_in);
        rst_in = 1'b0;
        repeat (LAT + 5) @(negedge clk_in);
        start_block(PT_C1, 0, 1, LAT, CT_C1);
        repeat (LAT + 5) @(negedge clk_in);

        // Stall: round_in = 12 for 5 cycles mid-block
        stall_at = 11;
        start_block(PT_B, 1, 1, LAT + 5, CT_B);
        repeat (LAT + 12) @(negedge clk_in);
        stall_at = -1;

        check("all_blocks_completed", 128'(sb_q.size()), 128'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
